// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Holds the FSM state encoding and the counter-width helper.
package mult_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int CNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-add multiplier.
// master drives operands and out_ready; slave returns ready/valid/product.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid,
    output is_signed,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  is_signed,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/seq_shift_add_multiplier_cond_negate.sv
// Conditional two's-complement negation: o_out = i_neg ? -i_in : i_in.
// Ports: i_in (N), i_neg (1), o_out (N).
module cond_negate #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_in,
  input  logic         i_neg,
  output logic [N-1:0] o_out
);

  assign o_out = i_neg ? (~i_in + 1'b1) : i_in;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned.
// Ports: clk, rst_n (async low), bus (slave handshake). Macro: EARLY_DONE_EN.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  seq_shift_add_multiplier_if.slave    bus
);

  localparam int CW = CNT_W(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t             r_state;
  logic [PW-1:0]      r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [PW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [PW-1:0]      r_product;

  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [PW-1:0]      w_acc_next;
  logic [PW-1:0]      w_res;
  logic               w_last;
  logic               w_a_neg;
  logic               w_b_neg;

  assign w_a_neg = bus.is_signed & bus.a[WIDTH-1];
  assign w_b_neg = bus.is_signed & bus.b[WIDTH-1];

  // |min| wraps to 2^(W-1), which is the right magnitude read as unsigned
  cond_negate #(.N(WIDTH)) u_neg_a (
    .i_in  (bus.a),
    .i_neg (w_a_neg),
    .o_out (w_a_abs)
  );

  cond_negate #(.N(WIDTH)) u_neg_b (
    .i_in  (bus.b),
    .i_neg (w_b_neg),
    .o_out (w_b_abs)
  );

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef EARLY_DONE_EN
  assign w_last = (r_cnt == CW'(1)) ||
                  ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  cond_negate #(.N(PW)) u_neg_p (
    .i_in  (w_acc_next),
    .i_neg (r_neg),
    .o_out (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
            r_mplier <= w_b_abs;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (w_last) begin
            r_product <= w_res;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.product   = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: directed table at WIDTH=8 plus random
// vectors at WIDTH=4/8/13 against an arithmetic reference model.
module tb_seq_shift_add_multiplier;

  localparam int NRND = 1500;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_rnd_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint ref_prod(input int w, input bit s,
                                      input longint a,
                                      input longint b);
    longint sa, sb, p;
    sa = a;
    sb = b;
    if (s && a[w-1]) sa = a - (64'sd1 << w);
    if (s && b[w-1]) sb = b - (64'sd1 << w);
    p = sa * sb;
    return p & ((64'sd1 << (2 * w)) - 1);
  endfunction

  function automatic int ref_lat(input int w, input bit s,
                                 input longint b);
`ifdef EARLY_DONE_EN
    longint m;
    int l;
    m = b;
    if (s && b[w-1]) m = (64'sd1 << w) - b;
    l = 1;
    for (int i = 0; i < w; i++)
      if (m[i]) l = i + 1;
    return l;
`else
    return w + 0 * int'(s) + 0 * int'(b[0]);
`endif
  endfunction

  // ---------------- directed WIDTH=8 instance ----------------
  seq_shift_add_multiplier_if #(.WIDTH(8)) bus8();

  seq_shift_add_multiplier #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  always @(negedge clk)
    chk("excl8", longint'(bus8.in_ready & bus8.out_valid), 0);

  typedef struct {
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat_full;
    int          lat_early;
  } vec_t;

  vec_t tbl[10];

  task automatic txn8(input bit s, input logic [7:0] a,
                      input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus8.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) chk("in_ready_timeout", 0, 1);
    bus8.is_signed = s;
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    p = bus8.product;
  endtask

  task automatic rel8();
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  // ---------------- random instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 13);
    bit done = 1'b0;

    seq_shift_add_multiplier_if #(.WIDTH(W)) rbus();

    seq_shift_add_multiplier #(.WIDTH(W)) u_r (
      .clk   (clk),
      .rst_n (rst_rnd_n),
      .bus   (rbus)
    );

    always @(negedge clk)
      if (rst_rnd_n)
        chk("excl_rnd", longint'(rbus.in_ready & rbus.out_valid), 0);

    initial begin : p_rnd
      logic [W-1:0] a, b;
      bit s;
      int lat, gd;
      rbus.in_valid  = 1'b0;
      rbus.is_signed = 1'b0;
      rbus.a         = '0;
      rbus.b         = '0;
      rbus.out_ready = 1'b0;
      wait (rst_rnd_n);
      for (int n = 0; n < NRND; n++) begin
        a = W'($urandom);
        b = W'($urandom);
        s = 1'($urandom_range(0, 1));
        @(negedge clk);
        gd = 0;
        while (!rbus.in_ready && gd < 20) begin
          @(negedge clk);
          gd++;
        end
        if (gd >= 20) chk("rnd_ready_timeout", 0, 1);
        rbus.a = a;
        rbus.b = b;
        rbus.is_signed = s;
        rbus.in_valid = 1'b1;
        @(negedge clk);
        rbus.in_valid = 1'b0;
        lat = 0;
        while (!rbus.out_valid && lat < W + 3) begin
          @(negedge clk);
          lat++;
        end
        chk("rnd_prod", longint'(rbus.product),
            ref_prod(W, s, longint'(a), longint'(b)));
        chk("rnd_lat", lat, ref_lat(W, s, longint'(b)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rbus.out_ready = 1'b1;
        @(negedge clk);
        rbus.out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : p_main
    logic [15:0] p;
    int lat, t;
    bit early;
`ifdef EARLY_DONE_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    tbl[0] = '{1'b0, 8'd255, 8'd255, 16'hFE01, 8, 8};
    tbl[1] = '{1'b1, 8'h80,  8'h80,  16'h4000, 8, 8};
    tbl[2] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 8, 3};
    tbl[3] = '{1'b1, 8'h7F,  8'hFF,  16'hFF81, 8, 1};
    tbl[4] = '{1'b0, 8'd6,   8'd7,   16'h002A, 8, 3};
    tbl[5] = '{1'b0, 8'hAB,  8'h00,  16'h0000, 8, 1};
    tbl[6] = '{1'b0, 8'hAB,  8'h01,  16'h00AB, 8, 1};
    tbl[7] = '{1'b0, 8'h03,  8'h80,  16'h0180, 8, 8};
    tbl[8] = '{1'b1, 8'h80,  8'h7F,  16'hC080, 8, 7};
    tbl[9] = '{1'b1, 8'h80,  8'h01,  16'hFF80, 8, 1};

    rst_n = 1'b0;
    rst_rnd_n = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.is_signed = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(bus8.in_ready), 1);
    chk("rst_out_valid", longint'(bus8.out_valid), 0);
    chk("rst_product", longint'(bus8.product), 0);
    rst_n = 1'b1;
    rst_rnd_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      txn8(tbl[i].s, tbl[i].a, tbl[i].b, p, lat);
      chk($sformatf("tbl%0d_prod", i), longint'(p), longint'(tbl[i].p));
      chk($sformatf("tbl%0d_lat", i), lat,
          early ? tbl[i].lat_early : tbl[i].lat_full);
      rel8();
      chk($sformatf("tbl%0d_idle", i), longint'(bus8.in_ready), 1);
    end

    // backpressure: result held, new operands ignored
    txn8(1'b0, 8'd12, 8'd13, p, lat);
    chk("bp_prod", longint'(p), 16'h009C);
    bus8.a = 8'd1;
    bus8.b = 8'd1;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", longint'(bus8.out_valid), 1);
      chk("bp_ready", longint'(bus8.in_ready), 0);
      chk("bp_hold", longint'(bus8.product), 16'h009C);
    end
    bus8.in_valid = 1'b0;
    rel8();
    chk("bp_rel_valid", longint'(bus8.out_valid), 0);
    chk("bp_rel_ready", longint'(bus8.in_ready), 1);
    chk("bp_rel_prod", longint'(bus8.product), 16'h009C);

    // reset in the third busy cycle aborts silently
    @(negedge clk);
    bus8.a = 8'd9;
    bus8.b = 8'd9;
    bus8.is_signed = 1'b0;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(bus8.out_valid), 0);
    chk("mid_rst_prod", longint'(bus8.product), 0);
    chk("mid_rst_ready", longint'(bus8.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    txn8(1'b0, 8'd6, 8'd7, p, lat);
    chk("post_rst_prod", longint'(p), 42);
    chk("post_rst_lat", lat, ref_lat(8, 1'b0, 7));
    rel8();

    t = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done)
           && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60000) chk("rnd_timeout", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
